// File: rtl/ar_pixel_pkg.sv
// Shared types and helpers for the AR overlay point generator.
package ar_pixel_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  typedef struct packed {
    logic [HCOUNT_W-1:0] x;
    logic [VCOUNT_W-1:0] y;
  } point_t;

  // Sums are one bit wider than the coordinates, so the halving never overflows.
  function automatic point_t midpoint(point_t a, point_t b);
    point_t            res;
    logic [HCOUNT_W:0] sx;
    logic [VCOUNT_W:0] sy;
    sx    = {1'b0, a.x} + {1'b0, b.x};
    sy    = {1'b0, a.y} + {1'b0, b.y};
    res.x = sx[HCOUNT_W:1];
    res.y = sy[VCOUNT_W:1];
    return res;
  endfunction

endpackage

// File: rtl/ar_point_matcher.sv
// Combinational hit test of the scan position against one virtual point.
// AR_PIXEL_BOX_EN widens the hit from an exact match to a 3x3 box.
module ar_point_matcher
  import ar_pixel_pkg::*;
(
  input  point_t              point,
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  output logic                hit
);

`ifdef AR_PIXEL_BOX_EN
  logic [HCOUNT_W-1:0] dx;
  logic [VCOUNT_W-1:0] dy;

  // Absolute distance on unsigned values, so the box clips at 0 instead of wrapping.
  always_comb begin
    dx  = (hcount >= point.x) ? (hcount - point.x) : (point.x - hcount);
    dy  = (vcount >= point.y) ? (vcount - point.y) : (point.y - vcount);
    hit = (dx <= HCOUNT_W'(1)) && (dy <= VCOUNT_W'(1));
  end
`else
  assign hit = (hcount == point.x) && (vcount == point.y);
`endif

endmodule

// File: rtl/ar_pixel_manager.sv
// Captures tracked points per frame, publishes tracked+midpoint virtual set at frame end,
// and renders a 1-cycle-latency pixel_out. Optional 3x3 box rendering via AR_PIXEL_BOX_EN.
module ar_pixel_manager
  import ar_pixel_pkg::*;
#(
  parameter int N_TRACKING_POINTS = 4,
  parameter int N_VIRTUAL_POINTS  = 8,
  parameter int FRAME_END_HCOUNT  = 320,
  parameter int FRAME_END_VCOUNT  = 640
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                data_valid_in,
  input  logic [HCOUNT_W-1:0] x_in,
  input  logic [VCOUNT_W-1:0] y_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                pixel_out
);

  localparam int CNT_W = $clog2(N_TRACKING_POINTS + 1);

  if (N_VIRTUAL_POINTS != 2 * N_TRACKING_POINTS) begin : g_bad_virtual
    $error("ar_pixel_manager: N_VIRTUAL_POINTS must equal 2*N_TRACKING_POINTS");
  end
  if (N_TRACKING_POINTS < 2) begin : g_bad_tracking
    $error("ar_pixel_manager: N_TRACKING_POINTS must be at least 2");
  end

  logic [CNT_W-1:0]            count;
  logic                        published_valid;
  point_t                      slot      [N_TRACKING_POINTS];
  point_t                      virt      [N_VIRTUAL_POINTS];
  point_t                      next_virt [N_VIRTUAL_POINTS];
  logic [N_VIRTUAL_POINTS-1:0] hits;
  point_t                      in_pt;
  logic                        frame_end;
  logic                        set_full;

  assign in_pt     = '{x: x_in, y: y_in};
  assign frame_end = (hcount_in == HCOUNT_W'(FRAME_END_HCOUNT)) &&
                     (vcount_in == VCOUNT_W'(FRAME_END_VCOUNT));
  assign set_full  = (count == CNT_W'(N_TRACKING_POINTS));

  for (genvar i = 0; i < N_TRACKING_POINTS; i++) begin : g_virt
    assign next_virt[i]                     = slot[i];
    assign next_virt[N_TRACKING_POINTS + i] =
      midpoint(slot[i], slot[(i + 1) % N_TRACKING_POINTS]);
  end

  for (genvar k = 0; k < N_VIRTUAL_POINTS; k++) begin : g_match
    ar_point_matcher u_match (
      .point  (virt[k]),
      .hcount (hcount_in),
      .vcount (vcount_in),
      .hit    (hits[k])
    );
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcount_out      <= '0;
      vcount_out      <= '0;
      pixel_out       <= 1'b0;
      count           <= '0;
      published_valid <= 1'b0;
      for (int i = 0; i < N_TRACKING_POINTS; i++) slot[i] <= '0;
      for (int k = 0; k < N_VIRTUAL_POINTS; k++) virt[k] <= '0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      pixel_out  <= published_valid && (|hits);

      if (frame_end) begin
        if (set_full) begin
          for (int k = 0; k < N_VIRTUAL_POINTS; k++) virt[k] <= next_virt[k];
          published_valid <= 1'b1;
        end
        // A sample on the frame-end cycle opens the next frame rather than closing this one.
        if (data_valid_in) begin
          slot[0] <= in_pt;
          count   <= CNT_W'(1);
        end else begin
          count <= '0;
        end
      end else if (data_valid_in && !set_full) begin
        for (int i = 0; i < N_TRACKING_POINTS; i++)
          if (count == CNT_W'(i)) slot[i] <= in_pt;
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ar_pixel_manager.sv
// Directed vector bench for ar_pixel_manager (default exact-match build).
module tb_ar_pixel_manager;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        pixel_out;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        dv;
    logic [10:0] x;
    logic [9:0]  y;
    logic        pix;
  } vec_t;

  vec_t vecs[$];

  ar_pixel_manager dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .data_valid_in (data_valid_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .pixel_out     (pixel_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void add(int h, int v, bit dv, int x, int y, bit pix);
    vec_t r;
    r.h = 11'(h); r.v = 10'(v); r.dv = dv; r.x = 11'(x); r.y = 10'(y); r.pix = pix;
    vecs.push_back(r);
  endfunction

  function automatic void scan(int h, int v, bit pix);
    add(h, v, 1'b0, 0, 0, pix);
  endfunction

  // Point delivered at a scan position that never coincides with a virtual point.
  function automatic void feed(int x, int y);
    add(700, 500, 1'b1, x, y, 1'b0);
  endfunction

  function automatic void fend(bit dv, int x, int y);
    add(320, 640, dv, x, y, 1'b0);
  endfunction

  task automatic step(input vec_t r, input string name);
    @(negedge clk_in);
    hcount_in     = r.h;
    vcount_in     = r.v;
    data_valid_in = r.dv;
    x_in          = r.x;
    y_in          = r.y;
    @(posedge clk_in);
    #1;
    n_vec++;
    if (pixel_out !== r.pix || hcount_out !== r.h || vcount_out !== r.v) begin
      n_fail++;
      $display("FAIL %s at (%0d,%0d): pixel_out=%0b want %0b, hcount_out=%0d want %0d, vcount_out=%0d want %0d",
               name, r.h, r.v, pixel_out, r.pix, hcount_out, r.h, vcount_out, r.v);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  task automatic check_zero_hv(input string name);
    n_vec++;
    if (hcount_out !== 11'd0 || vcount_out !== 10'd0) begin
      n_fail++;
      $display("FAIL %s: hcount_out=%0d vcount_out=%0d want 0,0", name, hcount_out, vcount_out);
    end
  endtask

  initial begin
    vec_t r;

    // Nothing published yet: everything dark, counters merely delayed.
    scan(0, 0, 0); scan(10, 0, 0); scan(319, 640, 0);
    fend(0, 0, 0);
    scan(10, 0, 0); scan(0, 1, 0);

    // Column of four points; midpoints truncate onto (10,0),(10,1),(10,2),(10,1).
    feed(10, 0); feed(10, 1); feed(10, 2); feed(10, 3);
    fend(0, 0, 0);
    scan(10, 0, 1); scan(10, 1, 1); scan(10, 2, 1); scan(10, 3, 1);
    scan(9, 0, 0); scan(11, 1, 0); scan(10, 4, 0);

    // Rectangle with non-trivial midpoints including the wrap-around pair.
    feed(20, 20); feed(30, 20); feed(30, 31); feed(20, 31);
    fend(0, 0, 0);
    scan(20, 20, 1); scan(30, 31, 1);
    scan(25, 20, 1); scan(30, 25, 1); scan(25, 31, 1); scan(20, 25, 1);
    scan(25, 25, 0); scan(10, 0, 0);

    // Short frame keeps the rectangle; the next frame starts counting from zero.
    feed(50, 50); feed(51, 51); feed(52, 52);
    fend(0, 0, 0);
    scan(25, 20, 1); scan(50, 50, 0);
    feed(60, 60); feed(62, 60); feed(62, 62); feed(60, 62);
    fend(0, 0, 0);
    scan(60, 60, 1); scan(61, 60, 1); scan(61, 62, 1); scan(25, 20, 0);

    // Six samples: the fifth and sixth are dropped.
    feed(100, 10); feed(102, 10); feed(102, 12); feed(100, 12);
    feed(200, 200); feed(201, 201);
    fend(0, 0, 0);
    scan(100, 10, 1); scan(101, 10, 1); scan(100, 11, 1);
    scan(200, 200, 0); scan(201, 201, 0); scan(60, 60, 0);

    // Sample on the frame-end cycle opens the next frame.
    feed(30, 30); feed(32, 30); feed(32, 32);
    fend(1, 4, 4);
    scan(100, 10, 1); scan(30, 30, 0); scan(4, 4, 0);
    feed(6, 4); feed(6, 6); feed(4, 6);
    fend(0, 0, 0);
    scan(4, 4, 1); scan(5, 4, 1); scan(6, 6, 1); scan(4, 5, 1);
    scan(5, 5, 0); scan(100, 10, 0); scan(30, 30, 0);

    // Reset state
    rst_in        = 1'b0;
    hcount_in     = '0;
    vcount_in     = '0;
    data_valid_in = 1'b0;
    x_in          = '0;
    y_in          = '0;
    #2;
    check_bit("reset_pixel", pixel_out, 1'b0);
    check_zero_hv("reset_hv");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a lit pixel.
    r = '{h: 11'd4, v: 10'd4, dv: 1'b0, x: 11'd0, y: 10'd0, pix: 1'b1};
    step(r, "pre_async_reset");
    #2;
    rst_in = 1'b0;
    #1;
    check_bit("async_reset_pixel", pixel_out, 1'b0);
    check_zero_hv("async_reset_hv");
    @(negedge clk_in);
    rst_in = 1'b1;
    r = '{h: 11'd4, v: 10'd4, dv: 1'b0, x: 11'd0, y: 10'd0, pix: 1'b0};
    step(r, "post_reset_dark");
    r = '{h: 11'd320, v: 10'd640, dv: 1'b0, x: 11'd0, y: 10'd0, pix: 1'b0};
    step(r, "post_reset_fend");
    r = '{h: 11'd6, v: 10'd6, dv: 1'b0, x: 11'd0, y: 10'd0, pix: 1'b0};
    step(r, "post_reset_still_dark");
    r = '{h: 11'd700, v: 10'd500, dv: 1'b1, x: 11'd8, y: 10'd8, pix: 1'b0};
    step(r, "refeed0");
    r.x = 11'd10; step(r, "refeed1");
    r.y = 10'd10; step(r, "refeed2");
    r.x = 11'd8;  step(r, "refeed3");
    r = '{h: 11'd320, v: 10'd640, dv: 1'b0, x: 11'd0, y: 10'd0, pix: 1'b0};
    step(r, "refeed_fend");
    r = '{h: 11'd9, v: 10'd8, dv: 1'b0, x: 11'd0, y: 10'd0, pix: 1'b1};
    step(r, "refeed_mid_lit");
    r = '{h: 11'd4, v: 10'd4, dv: 1'b0, x: 11'd0, y: 10'd0, pix: 1'b0};
    step(r, "old_set_gone");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
